// File: rtl/cl_defs.sv
// Shared definitions for chart metadata words, used by the assembler and the
// metadata controller.
package cl_defs;

    localparam int MAX_WORDS      = 4096;
    localparam int TIMEOUT_CYCLES = 2500000;

    typedef enum logic [2:0] {
        SYS_NOTE = 3'b000,
        SYS_END  = 3'b111
    } sys_t;

    typedef struct packed {
        sys_t        sys;        // [31:29]
        logic [5:0]  pitch;      // [28:23]
        logic [2:0]  string_no;  // [22:20]
        logic [3:0]  fret;       // [19:16]
        logic [15:0] tstamp;     // [15:0]
    } meta_word_t;

    localparam logic [31:0] END_WORD = {SYS_END, 29'd0};

    function automatic logic is_end_word(input logic [31:0] w);
        meta_word_t m;
        m = meta_word_t'(w);
        return m.sys == SYS_END;
    endfunction

endpackage

// File: rtl/cl_word_assembler_idle_timer.sv
// Idle timer for a partial word: restarts on every byte, pulses expire when
// CYCLES cycles pass without one.
module cl_idle_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk25,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign expire = run && !clr && (cnt == LAST);

    always_ff @(posedge clk25) begin
        if (reset || clr || !run || expire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/cl_word_assembler.sv
// Packs the received byte stream MSB-first into 32-bit metadata words, stops on
// an end word, and substitutes END_WORD when the word store is about to fill.
module cl_word_assembler #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int MAX_WORDS      = 4096,
    localparam int CW            = $clog2(MAX_WORDS) + 1
) (
    input  logic          clk25,
    input  logic          reset,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          write_en,
    output logic [31:0]   write_word,
    output logic [CW-1:0] word_count,
    output logic          done,
    output logic          busy,
    output logic          timeout_err,
    output logic          overflow_err
);

    import cl_defs::*;

    typedef enum logic {COLLECT, DONE} state_t;

    localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_WORDS - 1);
    localparam logic [CW-1:0] FULL      = CW'(MAX_WORDS);

    state_t        state, state_n;
    logic [31:0]   shreg, shreg_n, assembled;
    logic [1:0]    byte_idx, idx_n;
    logic          wen_n, done_n, terr_n, oerr_n;
    logic [31:0]   wword_n;
    logic [CW-1:0] cnt_n;
    logic          accept, expire;

    assign accept = byte_valid && (state == COLLECT);

    cl_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk25  (clk25),
        .reset  (reset),
        .run    ((byte_idx != 2'd0) && (state == COLLECT)),
        .clr    (accept),
        .expire (expire)
    );

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        idx_n     = byte_idx;
        wen_n     = 1'b0;
        wword_n   = write_word;
        cnt_n     = word_count;
        done_n    = done;
        terr_n    = timeout_err;
        oerr_n    = overflow_err;
        assembled = {shreg[23:0], byte_data};
        if (state == COLLECT) begin
            if (accept) begin
                shreg_n = assembled;
                idx_n   = byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    wen_n   = 1'b1;
                    shreg_n = '0;
                    cnt_n   = (word_count == FULL) ? word_count : word_count + 1'b1;
                    wword_n = assembled;
                    if (is_end_word(assembled)) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else if (word_count == LAST_SLOT) begin
                        // Last free slot must hold an end word.
                        wword_n = END_WORD;
                        done_n  = 1'b1;
                        oerr_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end else if (expire) begin
                idx_n   = 2'd0;
                shreg_n = '0;
                terr_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state        <= COLLECT;
            shreg        <= '0;
            byte_idx     <= 2'd0;
            write_en     <= 1'b0;
            write_word   <= '0;
            word_count   <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state        <= state_n;
            shreg        <= shreg_n;
            byte_idx     <= idx_n;
            write_en     <= wen_n;
            write_word   <= wword_n;
            word_count   <= cnt_n;
            done         <= done_n;
            busy         <= (idx_n != 2'd0);
            timeout_err  <= terr_n;
            overflow_err <= oerr_n;
        end
    end

endmodule

// File: tb/tb_cl_word_assembler.sv
// Directed bench for cl_word_assembler with an expected-word scoreboard.
module tb_cl_word_assembler;

    localparam int TO  = 16;
    localparam int MW  = 4;
    localparam int CW  = $clog2(MW) + 1;
    localparam logic [31:0] ENDW = 32'hE000_0000;

    logic          clk25 = 1'b0;
    logic          reset = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          write_en;
    logic [31:0]   write_word;
    logic [CW-1:0] word_count;
    logic          done, busy, timeout_err, overflow_err;

    int errors = 0;
    int checks = 0;
    int wen_total = 0;
    logic wen_prev = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] m_shreg;
    int          m_idx, m_count;
    logic        m_done;

    cl_word_assembler #(.TIMEOUT_CYCLES(TO), .MAX_WORDS(MW)) dut (
        .clk25        (clk25),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .write_en     (write_en),
        .write_word   (write_word),
        .word_count   (word_count),
        .done         (done),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .overflow_err (overflow_err)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write strobe must match the oldest expected word.
    always @(negedge clk25) begin
        if (write_en) begin
            wen_total++;
            check("wen_back_to_back", {31'd0, wen_prev}, 32'd0);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%h expected=none", write_word);
            end
            if (exp_q.size() != 0) check("write_word", write_word, exp_q.pop_front());
        end
        wen_prev = write_en;
    end

    task automatic model_clear();
        m_shreg = '0;
        m_idx   = 0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk25);
        #1 reset = 1'b0;
        model_clear();
        m_count = 0;
        m_done  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (!m_done) begin
            m_shreg = {m_shreg[23:0], b};
            m_idx++;
            if (m_idx == 4) begin
                if (m_shreg[31:29] == 3'b111) begin
                    exp_q.push_back(m_shreg);
                    m_done = 1'b1;
                end else if (m_count == MW - 1) begin
                    exp_q.push_back(ENDW);
                    m_done = 1'b1;
                end else begin
                    exp_q.push_back(m_shreg);
                end
                m_count++;
                model_clear();
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk25);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    initial begin
        int base;
        model_clear();
        m_count = 0;
        m_done  = 1'b0;
        do_reset(3);

        // Reset state
        @(negedge clk25);
        check("rst_write_en", {31'd0, write_en}, 32'd0);
        check("rst_write_word", write_word, 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_overflow_err", {31'd0, overflow_err}, 32'd0);

        // Normal word
        #1;
        base = wen_total;
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk25);
        check("mid_busy", {31'd0, busy}, 32'd1);
        #1;
        send_byte(8'h56);
        send_byte(8'h78);
        @(negedge clk25);
        check("norm_write_en", {31'd0, write_en}, 32'd1);
        check("norm_count", 32'(word_count), 32'd1);
        check("norm_done", {31'd0, done}, 32'd0);
        check("norm_busy", {31'd0, busy}, 32'd0);
        idle(3);
        check("norm_wen_total", 32'(wen_total - base), 32'd1);
        check("norm_drain", 32'(exp_q.size()), 32'd0);

        // End word, then bytes ignored in DONE
        do_reset(1);
        base = wen_total;
        send_word(32'h0A1B_0010);
        send_word(32'hE000_0000);
        @(negedge clk25);
        check("end_write_en", {31'd0, write_en}, 32'd1);
        check("end_done", {31'd0, done}, 32'd1);
        check("end_count", 32'(word_count), 32'd2);
        #1;
        send_word(32'h1122_3344);
        idle(3);
        check("end_ignored_wen", 32'(wen_total - base), 32'd2);
        check("end_hold_count", 32'(word_count), 32'd2);
        check("end_hold_done", {31'd0, done}, 32'd1);
        check("end_hold_word", write_word, 32'hE000_0000);
        check("end_drain", 32'(exp_q.size()), 32'd0);

        // Timeout discards the partial word
        do_reset(1);
        base = wen_total;
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(TO - 1);
        check("to_not_yet", {31'd0, timeout_err}, 32'd0);
        check("to_busy_pre", {31'd0, busy}, 32'd1);
        idle(1);
        model_clear();
        check("to_err", {31'd0, timeout_err}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_no_wen", 32'(wen_total - base), 32'd0);
        send_word(32'h0102_0304);
        idle(1);
        check("to_after_count", 32'(word_count), 32'd1);
        check("to_sticky", {31'd0, timeout_err}, 32'd1);
        check("to_drain", 32'(exp_q.size()), 32'd0);

        // Byte on the expiry cycle wins
        do_reset(1);
        send_byte(8'hC1);
        send_byte(8'hC2);
        idle(TO - 1);
        send_byte(8'hC3);
        send_byte(8'hC4);
        @(negedge clk25);
        check("race_wen", {31'd0, write_en}, 32'd1);
        check("race_err", {31'd0, timeout_err}, 32'd0);
        idle(1);
        check("race_count", 32'(word_count), 32'd1);
        check("race_drain", 32'(exp_q.size()), 32'd0);

        // Overflow substitutes the end word in the last slot
        do_reset(1);
        for (int i = 1; i <= 4; i++) send_word(32'(i));
        @(negedge clk25);
        check("ovf_word", write_word, ENDW);
        check("ovf_err", {31'd0, overflow_err}, 32'd1);
        check("ovf_done", {31'd0, done}, 32'd1);
        check("ovf_count", 32'(word_count), 32'd4);
        idle(1);
        check("ovf_drain", 32'(exp_q.size()), 32'd0);

        // Reset mid-word drops the partial word
        do_reset(1);
        base = wen_total;
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset(1);
        send_word(32'h3344_5566);
        idle(2);
        check("rmw_wen", 32'(wen_total - base), 32'd1);
        check("rmw_count", 32'(word_count), 32'd1);
        check("rmw_terr", {31'd0, timeout_err}, 32'd0);
        check("rmw_oerr", {31'd0, overflow_err}, 32'd0);
        check("rmw_done", {31'd0, done}, 32'd0);
        check("rmw_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
